// File: rtl/paddsb_if.sv
// PADDSB sequencer handshake bundle: start/operands in, busy/done/result out.
// The pipeline side drives the master modport; the execution unit is the slave.
interface paddsb_if #(
  parameter int LANES = 4
);
  logic                 start;
  logic [4*LANES-1:0]   rs;
  logic [4*LANES-1:0]   rt;
  logic                 busy;
  logic                 done;
  logic [4*LANES-1:0]   rd;
  logic [LANES-1:0]     sat_flags;
  logic                 ovf;

  modport master (
    output start, rs, rt,
    input  busy, done, rd, sat_flags, ovf
  );

  modport slave (
    input  start, rs, rt,
    output busy, done, rd, sat_flags, ovf
  );
endinterface

// File: rtl/paddsb_seq.sv
// Area-reduced PADDSB unit: one 4-bit saturating adder time-shared
// across all nibble lanes, one lane per clock.
module paddsb_seq #(
  parameter int LANES = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  paddsb_if.slave  bus
);
  localparam int W  = 4 * LANES;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     work;
  logic [LANES-1:0] wflags;
  logic [W-1:0]     rd_q;
  logic [LANES-1:0] sat_q;
  logic             ovf_q;

  logic [3:0]       a;
  logic [3:0]       b;
  logic [3:0]       s;
  logic             pos;
  logic             neg;
  logic [3:0]       lane;
  logic [W-1:0]     nxt_work;
  logic [LANES-1:0] nxt_flags;
  logic             last;

  assign a    = op_a[cnt*4 +: 4];
  assign b    = op_b[cnt*4 +: 4];
  assign s    = a + b;
  assign pos  = ~a[3] & ~b[3] &  s[3];
  assign neg  =  a[3] &  b[3] & ~s[3];
  assign last = (cnt == CW'(LANES - 1));

  always_comb begin
    lane = s;
    unique case (1'b1)
      pos:     lane = 4'h7;
      neg:     lane = 4'h8;
      default: lane = s;
    endcase
  end

  // Merge this cycle's lane so the final edge can publish the full word.
  always_comb begin
    nxt_work             = work;
    nxt_flags            = wflags;
    nxt_work[cnt*4 +: 4] = lane;
    nxt_flags[cnt]       = pos | neg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      work   <= '0;
      wflags <= '0;
      rd_q   <= '0;
      sat_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_a   <= bus.rs;
            op_b   <= bus.rt;
            work   <= '0;
            wflags <= '0;
            cnt    <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          work   <= nxt_work;
          wflags <= nxt_flags;
          if (last) begin
            rd_q  <= nxt_work;
            sat_q <= nxt_flags;
            ovf_q <= |nxt_flags;
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == S_CALC);
  assign bus.done      = (state == S_DONE);
  assign bus.rd        = rd_q;
  assign bus.sat_flags = sat_q;
  assign bus.ovf       = ovf_q;
endmodule
